// File: rtl/up_sample_interp.sv
// up_sample_interp: FIFO-buffered sample-rate up-converter driven by a 32-bit phase accumulator,
// producing linear interpolation or zero-order hold at the full clk_DA rate.
module up_sample_interp #(
    parameter int DATA_W  = 12,
    parameter int FIFO_AW = 3,
    parameter int FRAC_W  = 8
) (
    input  logic              clk_DA,
    input  logic              rst_n,
    input  logic [31:0]       sample_fre,
    input  logic              interp_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              clk_sample,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              underflow
);
    typedef enum logic [1:0] {IDLE, PRIME0, PRIME1, RUN} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem_q [2**FIFO_AW];
    logic [FIFO_AW:0] wr_q, rd_q;
    logic [31:0] addr_q, addr_d;
    logic signed [DATA_W-1:0] s0_q, s0_d, s1_q, s1_d;
    logic under_q, under_d;
    logic [32:0] sum;
    logic [DATA_W-1:0] head;
    logic push, pop, empty, adv;
    logic v1_q, v2_q;
    logic signed [DATA_W-1:0] p_s0_q;
    logic signed [DATA_W:0] diff_q;
    logic [FRAC_W-1:0] frac_q;
    logic [DATA_W-1:0] out_q, interp;
    logic signed [DATA_W+FRAC_W:0] prod;

    assign fifo_level     = wr_q - rd_q;
    assign empty          = fifo_level == '0;
    // level never exceeds 2^FIFO_AW, so the MSB alone flags full
    assign data_in_ready  = !fifo_level[FIFO_AW];
    assign push           = data_in_valid && data_in_ready;
    assign head           = mem_q[rd_q[FIFO_AW-1:0]];
    assign sum            = {1'b0, addr_q} + {1'b0, sample_fre};
    assign adv            = state_q == RUN && sum[32];
    assign clk_sample     = addr_q[31];
    assign underflow      = under_q;
    assign data_out       = out_q;
    assign data_out_valid = v2_q;
    assign prod   = $signed({{FRAC_W{diff_q[DATA_W]}}, diff_q}) * $signed({{(DATA_W+1){1'b0}}, frac_q});
    assign interp = p_s0_q + DATA_W'(prod >>> FRAC_W);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        under_d = under_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:   state_d = fifo_level >= (FIFO_AW+1)'(2) ? PRIME0 : IDLE;
            PRIME0: begin
                pop     = 1'b1;
                s0_d    = head;
                state_d = PRIME1;
            end
            PRIME1: begin
                pop     = 1'b1;
                s1_d    = head;
                addr_d  = '0;
                state_d = RUN;
            end
            default: begin
                addr_d = sum[31:0];
                if (adv) begin
                    s0_d    = s1_q;
                    s1_d    = empty ? s1_q : head;
                    pop     = !empty;
                    under_d = under_q | empty;
                end
            end
        endcase
    end

    always_ff @(posedge clk_DA) begin
        if (push) mem_q[wr_q[FIFO_AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk_DA) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            under_q <= 1'b0;
            v1_q    <= 1'b0;
            p_s0_q  <= '0;
            diff_q  <= '0;
            frac_q  <= '0;
            out_q   <= '0;
            v2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            under_q <= under_d;
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            v1_q    <= state_q == RUN;
            p_s0_q  <= s0_q;
            diff_q  <= {s1_q[DATA_W-1], s1_q} - {s0_q[DATA_W-1], s0_q};
            frac_q  <= addr_q[31 -: FRAC_W];
            out_q   <= interp_en ? interp : p_s0_q;
            v2_q    <= v1_q;
        end
    end
endmodule

// File: tb/tb_up_sample_interp.sv
// tb_up_sample_interp: directed and randomized checks of up_sample_interp against a
// queue-based behavioural model of the up-converter.
module tb_up_sample_interp;
    logic        clk_DA = 1'b0;
    logic        rst_n, interp_en, data_in_valid;
    logic [31:0] sample_fre;
    logic [11:0] data_in;
    logic        data_in_ready, data_out_valid, clk_sample, underflow;
    logic [11:0] data_out;
    logic [3:0]  fifo_level;
    int checks = 0, errors = 0;

    always #5 clk_DA = ~clk_DA;

    up_sample_interp dut (
        .clk_DA(clk_DA), .rst_n(rst_n), .sample_fre(sample_fre), .interp_en(interp_en),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .clk_sample(clk_sample),
        .fifo_level(fifo_level), .underflow(underflow)
    );

    // Model: buffered samples, the two replay samples, phase and a two-deep output delay.
    int q[$];
    int s0, s1, primed, t_s0, t_s1, t_frac, m_out;
    bit started, t_v, m_v, und;
    bit [31:0] maddr;

    function automatic void model_edge();
        longint sum;
        bit pushing;
        if (!rst_n) begin
            q.delete();
            s0 = 0; s1 = 0; primed = 0; started = 0; maddr = 0; und = 0;
            t_v = 0; t_s0 = 0; t_s1 = 0; t_frac = 0; m_out = 0; m_v = 0;
            return;
        end
        m_out = interp_en ? t_s0 + (((t_s1 - t_s0) * t_frac) >>> 8) : t_s0;
        m_v = t_v;
        t_v = primed == 2; t_s0 = s0; t_s1 = s1; t_frac = int'(maddr[31:24]);
        pushing = data_in_valid && q.size() < 8;
        if (primed == 2) begin
            sum = longint'(maddr) + longint'(sample_fre);
            maddr = sum[31:0];
            if (sum >= 64'h1_0000_0000) begin
                s0 = s1;
                if (q.size() > 0) s1 = q.pop_front();
                else und = 1;
            end
        end else if (started) begin
            if (primed == 0) s0 = q.pop_front();
            else begin
                s1 = q.pop_front();
                maddr = 0;
            end
            primed++;
        end else started = q.size() >= 2;
        if (pushing) q.push_back(int'($signed(data_in)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input int e);
        chk(tag, {20'b0, data_out}, {20'b0, e[11:0]});
    endtask

    task automatic tick();
        @(posedge clk_DA);
        model_edge();
        #1;
        chk("data_out", {20'b0, data_out}, {20'b0, m_out[11:0]});
        chk("data_out_valid", {31'b0, data_out_valid}, {31'b0, m_v});
        chk("clk_sample", {31'b0, clk_sample}, {31'b0, maddr[31]});
        chk("fifo_level", {28'b0, fifo_level}, q.size());
        chk("data_in_ready", {31'b0, data_in_ready}, {31'b0, q.size() < 8});
        chk("underflow", {31'b0, underflow}, {31'b0, und});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input int v);
        data_in = v[11:0];
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int n = 0; n < budget && !data_out_valid; n++) tick();
        chk("wait_valid", {31'b0, data_out_valid}, 32'd1);
    endtask

    int ramp[8] = '{0, 100, 200, 300, 400, 500, 600, 700};
    int zoh[9]  = '{0, 0, 0, 0, 400, 400, 400, 400, 800};
    int neg[5]  = '{1000, 500, 0, -500, -1000};
    int flr[8]  = '{1000, 750, 500, 250, 0, -250, -500, -750};
    int pat[4]  = '{0, 400, 800, 1200};

    initial begin
        rst_n = 1'b0; sample_fre = '0; interp_en = 1'b1; data_in = '0; data_in_valid = 1'b0;
        tick();
        do_reset();
        chk("rst_data_out", {20'b0, data_out}, 32'd0);
        chk("rst_level", {28'b0, fifo_level}, 32'd0);
        chk("rst_valid", {31'b0, data_out_valid}, 32'd0);

        sample_fre = 32'h4000_0000;
        foreach (pat[i]) push(pat[i]);
        wait_valid(20);
        foreach (ramp[i]) begin chk_d("ramp", ramp[i]); tick(); end

        do_reset();
        interp_en = 1'b0;
        foreach (pat[i]) push(pat[i]);
        wait_valid(20);
        foreach (zoh[i]) begin chk_d("zoh", zoh[i]); tick(); end

        do_reset();
        interp_en = 1'b1;
        push(1000); push(-1000);
        wait_valid(20);
        foreach (neg[i]) begin chk_d("neg_slope", neg[i]); tick(); end

        do_reset();
        sample_fre = 32'h2000_0000;
        push(1000); push(-999);
        wait_valid(20);
        foreach (flr[i]) begin chk_d("floor_shift", flr[i]); tick(); end

        do_reset();
        sample_fre = '0;
        data_in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin data_in = 12'($urandom); tick(); end
        chk("full_level", {28'b0, fifo_level}, 32'd8);
        chk("full_ready", {31'b0, data_in_ready}, 32'd0);
        tick(); tick();
        chk("full_hold", {28'b0, fifo_level}, 32'd8);
        data_in_valid = 1'b0;

        do_reset();
        sample_fre = 32'h8000_0000;
        push(100); push(200); push(-300);
        for (int i = 0; i < 11; i++) tick();
        chk("underflow_set", {31'b0, underflow}, 32'd1);
        chk_d("underflow_hold", -300);
        push(500); push(700);
        for (int i = 0; i < 10; i++) tick();
        chk("underflow_sticky", {31'b0, underflow}, 32'd1);

        do_reset();
        sample_fre = '0;
        for (int i = 0; i < 7; i++) push(i * 50);
        tick(); tick();
        chk("run_level", {28'b0, fifo_level}, 32'd5);
        chk("run_valid", {31'b0, data_out_valid}, 32'd1);
        do_reset();
        chk_d("midrst_data", 0);
        chk("midrst_level", {28'b0, fifo_level}, 32'd0);
        chk("midrst_under", {31'b0, underflow}, 32'd0);
        chk("midrst_valid", {31'b0, data_out_valid}, 32'd0);
        sample_fre = 32'h1000_0000;
        push(33);
        for (int i = 0; i < 6; i++) tick();
        chk("one_sample_idle", {31'b0, data_out_valid}, 32'd0);
        push(-77);
        wait_valid(10);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 4))
                    0: sample_fre = '0;
                    1: sample_fre = 32'h4000_0000;
                    2: sample_fre = 32'h2000_0000;
                    3: sample_fre = $urandom;
                    default: sample_fre = $urandom >> 2;
                endcase
                interp_en = 1'($urandom);
            end
            rst_n = $urandom_range(0, 499) != 0;
            data_in_valid = 1'($urandom);
            data_in = 12'($urandom);
            tick();
        end
        rst_n = 1'b1;
        data_in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
